apb_gpio_bridge: RTL and testbench

- Second-generation APB slave front end for the GPIO core.
- Parametrised data and address width, with APB4 byte strobes, programmable wait states and address decode with PSLVERR.
- Registers the GPIO-side address, data and strobes, and issues a one-cycle access strobe per transfer.
- Tracks APB protocol violations in a sticky flag.
- Sits between the system APB fabric and the GPIO register core.

---
 rtl/apb_gpio_bridge.sv | 182 ++++++++++++++++++
 tb/tb_apb_gpio_bridge.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_bridge.sv
// apb_gpio_bridge: APB4 slave front end for the GPIO register core.
//
// Decodes an NWORDS-word window at BASE_ADDR. Address, write data and strobes
// are latched while the FSM enters SETUP; one gpio_stb pulse is issued on the
// first ACCESS cycle. pready follows after WAIT_CYCLES extra ACCESS cycles.
// Bad decodes end with pslverr and no strobe. Bus-protocol violations set a
// sticky proto_err flag.
//
// Ports:
//   pclk, prst          clock, asynchronous active-low reset
//   psel, penable,      APB request: select, enable, direction,
//   pwrite, paddr,      byte address,
//   pwdata, pstrb       write data and byte strobes
//   pready, prdata,     APB response: completion, read data,
//   pslverr             decode error
//   gpio_dat_o          read data from the GPIO core (combinational on gpio_addr)
//   gpio_inta_o         GPIO interrupt request
//   gpio_addr           word offset into the GPIO window
//   gpio_dat_i          write data to the GPIO core
//   gpio_sel            byte enables (pstrb on writes, all ones on reads)
//   gpio_we, gpio_stb   write qualifier and one-cycle access strobe
//   irq                 interrupt to the system
//   proto_err, err_clr  sticky protocol-violation flag and its clear
module apb_gpio_bridge #(
    parameter int unsigned   DW          = 32,
    parameter int unsigned   AW          = 32,
    parameter logic [AW-1:0] BASE_ADDR   = '0,
    parameter int unsigned   NWORDS      = 16,
    parameter int unsigned   WAIT_CYCLES = 0,
    parameter bit            IRQ_REG     = 1'b1,
    localparam int unsigned  GAW         = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic            pclk,
    input  logic            prst,
    input  logic            psel,
    input  logic            penable,
    input  logic            pwrite,
    input  logic [AW-1:0]   paddr,
    input  logic [DW-1:0]   pwdata,
    input  logic [DW/8-1:0] pstrb,
    output logic            pready,
    output logic [DW-1:0]   prdata,
    output logic            pslverr,
    input  logic [DW-1:0]   gpio_dat_o,
    input  logic            gpio_inta_o,
    output logic [GAW-1:0]  gpio_addr,
    output logic [DW-1:0]   gpio_dat_i,
    output logic [DW/8-1:0] gpio_sel,
    output logic            gpio_we,
    output logic            gpio_stb,
    output logic            irq,
    output logic            proto_err,
    input  logic            err_clr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    typedef logic [AW:0] ext_t;

    localparam int unsigned BYTES      = DW / 8;
    localparam int unsigned BL         = $clog2(BYTES);
    // Window bounds carry one extra bit so a window ending at the top of the
    // address space does not wrap.
    localparam ext_t        WIN_LO     = ext_t'(BASE_ADDR);
    localparam ext_t        WIN_HI     = WIN_LO + ext_t'(NWORDS * BYTES);
    localparam ext_t        ALIGN_MASK = ext_t'(BYTES - 1);
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

    state_t              state;
    logic [3:0]          wait_cnt;
    logic                pwrite_q;
    logic                err_q;
    logic [DW-1:0]       wdata_q;
    logic [BYTES-1:0]    sel_q;

    ext_t                addr_ext;
    ext_t                offset;
    logic                decode_err;
    logic [GAW-1:0]      word_idx;
    logic                ready_now;
    logic                load_setup;
    logic                viol;

    always_comb begin
        addr_ext   = {1'b0, paddr};
        offset     = addr_ext - WIN_LO;
        decode_err = (addr_ext < WIN_LO) || (addr_ext >= WIN_HI) ||
                     ((addr_ext & ALIGN_MASK) != '0);
        word_idx   = GAW'(offset >> BL);
    end

    assign ready_now = (state == ACCESS) && (wait_cnt == 4'd0);

    // Every path into SETUP (from IDLE, a repeated setup phase, or a
    // back-to-back request on the pready cycle) relatches the request.
    assign load_setup = psel && !penable &&
                        ((state == IDLE) || (state == SETUP) || ready_now);

    always_comb begin
        viol = 1'b0;
        unique case (state)
            IDLE:    viol = psel && penable;
            SETUP:   viol = !(psel && penable);
            ACCESS:  viol = ready_now ? (psel && penable) : !(psel && penable);
            default: viol = 1'b0;
        endcase
    end

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            pwrite_q   <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            sel_q      <= '0;
            gpio_addr  <= '0;
            gpio_dat_i <= '0;
            gpio_sel   <= '0;
            gpio_we    <= 1'b0;
            gpio_stb   <= 1'b0;
        end else begin
            gpio_stb <= 1'b0;
            gpio_we  <= 1'b0;

            if (load_setup) begin
                pwrite_q  <= pwrite;
                wdata_q   <= pwdata;
                sel_q     <= pwrite ? pstrb : '1;
                err_q     <= decode_err;
                gpio_addr <= word_idx;
            end

            unique case (state)
                IDLE: begin
                    if (psel && !penable) state <= SETUP;
                end
                SETUP: begin
                    if (psel && penable) begin
                        state      <= ACCESS;
                        wait_cnt   <= WAIT_LOAD;
                        gpio_stb   <= !err_q;
                        gpio_we    <= pwrite_q && !err_q;
                        gpio_sel   <= sel_q;
                        gpio_dat_i <= wdata_q;
                    end else if (!psel) begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (ready_now) begin
                        state <= (psel && !penable) ? SETUP : IDLE;
                    end else if (psel && penable) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pready  = ready_now;
    assign pslverr = ready_now && err_q;
    assign prdata  = (ready_now && !pwrite_q && !err_q) ? gpio_dat_o : '0;

    // Set wins over clear so a violation in the clearing cycle is not lost.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) proto_err <= 1'b0;
        else       proto_err <= viol || (proto_err && !err_clr);
    end

    if (IRQ_REG) begin : g_irq_reg
        always_ff @(posedge pclk or negedge prst) begin
            if (!prst) irq <= 1'b0;
            else       irq <= gpio_inta_o;
        end
    end else begin : g_irq_comb
        assign irq = gpio_inta_o;
    end

endmodule

// File: tb/tb_apb_gpio_bridge.sv
// tb_apb_gpio_bridge: directed bench for apb_gpio_bridge.
// Two instances share the bus stimulus: dut_a (no wait states, registered irq)
// and dut_b (two wait states, combinational irq), both at BASE_ADDR 0x100.
module tb_apb_gpio_bridge;

    logic        pclk = 1'b0;
    logic        prst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] gpio_dat_o;
    logic        gpio_inta_o;
    logic        err_clr;

    logic        pready_a, pslverr_a, gwe_a, gstb_a, irq_a, perr_a;
    logic [31:0] prdata_a, gdat_a;
    logic [3:0]  gaddr_a, gsel_a;
    logic        pready_b, pslverr_b, gwe_b, gstb_b, irq_b, perr_b;
    logic [31:0] prdata_b, gdat_b;
    logic [3:0]  gaddr_b, gsel_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 pclk = ~pclk;

    apb_gpio_bridge #(.DW(32), .AW(32), .BASE_ADDR(32'h100), .NWORDS(16),
                      .WAIT_CYCLES(0), .IRQ_REG(1'b1)) dut_a (
        .pclk(pclk), .prst(prst), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a),
        .gpio_dat_o(gpio_dat_o), .gpio_inta_o(gpio_inta_o),
        .gpio_addr(gaddr_a), .gpio_dat_i(gdat_a), .gpio_sel(gsel_a),
        .gpio_we(gwe_a), .gpio_stb(gstb_a), .irq(irq_a),
        .proto_err(perr_a), .err_clr(err_clr));

    apb_gpio_bridge #(.DW(32), .AW(32), .BASE_ADDR(32'h100), .NWORDS(16),
                      .WAIT_CYCLES(2), .IRQ_REG(1'b0)) dut_b (
        .pclk(pclk), .prst(prst), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b),
        .gpio_dat_o(gpio_dat_o), .gpio_inta_o(gpio_inta_o),
        .gpio_addr(gaddr_b), .gpio_dat_i(gdat_b), .gpio_sel(gsel_b),
        .gpio_we(gwe_b), .gpio_stb(gstb_b), .irq(irq_b),
        .proto_err(perr_b), .err_clr(err_clr));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic sample();
        @(negedge pclk);
    endtask

    task automatic drive(input logic s, input logic e, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        psel = s; penable = e; pwrite = w; paddr = a; pwdata = d; pstrb = st;
    endtask

    task automatic check_all_zero(input string who);
        check({who, "_pready"},  who == "a" ? pready_a  : pready_b,  0);
        check({who, "_prdata"},  who == "a" ? prdata_a  : prdata_b,  0);
        check({who, "_pslverr"}, who == "a" ? pslverr_a : pslverr_b, 0);
        check({who, "_gaddr"},   who == "a" ? gaddr_a   : gaddr_b,   0);
        check({who, "_gdat"},    who == "a" ? gdat_a    : gdat_b,    0);
        check({who, "_gsel"},    who == "a" ? gsel_a    : gsel_b,    0);
        check({who, "_gwe"},     who == "a" ? gwe_a     : gwe_b,     0);
        check({who, "_gstb"},    who == "a" ? gstb_a    : gstb_b,    0);
        check({who, "_irq"},     who == "a" ? irq_a     : irq_b,     0);
        check({who, "_perr"},    who == "a" ? perr_a    : perr_b,    0);
    endtask

    initial begin
        prst = 1'b0; err_clr = 1'b0; gpio_inta_o = 1'b0;
        gpio_dat_o = 32'h1234_5678;
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        #12;
        check_all_zero("a");
        check_all_zero("b");
        step();
        prst = 1'b1;

        // Write 0x108 on dut_a: strobe and pready on the first ACCESS cycle.
        drive(1, 0, 1, 32'h108, 32'hDEAD_BEEF, 4'b0101);
        sample(); check("wr_idle_pready", pready_a, 0);
        step(); penable = 1'b1;
        sample(); check("wr_setup_stb", gstb_a, 0); check("wr_gaddr", gaddr_a, 2);
        step(); drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        sample();
        check("wr_stb", gstb_a, 1); check("wr_we", gwe_a, 1);
        check("wr_sel", gsel_a, 4'b0101); check("wr_dat", gdat_a, 32'hDEAD_BEEF);
        check("wr_pready", pready_a, 1); check("wr_pslverr", pslverr_a, 0);
        step();
        sample();
        check("wr_stb_off", gstb_a, 0); check("wr_we_off", gwe_a, 0);
        check("wr_pready_off", pready_a, 0);
        check("wr_sel_hold", gsel_a, 4'b0101); check("wr_dat_hold", gdat_a, 32'hDEAD_BEEF);
        step();

        // Read 0x104 on dut_b: pready on the third ACCESS cycle.
        drive(1, 0, 0, 32'h104, 32'h0, 4'h0);
        sample(); check("rd_prdata_c0", prdata_b, 0);
        step(); penable = 1'b1;
        sample(); check("rd_prdata_c1", prdata_b, 0); check("rd_pready_c1", pready_b, 0);
        check("rd_gaddr", gaddr_b, 1);
        step();
        sample();
        check("rd_stb", gstb_b, 1); check("rd_we", gwe_b, 0); check("rd_sel", gsel_b, 4'hF);
        check("rd_pready_a1", pready_b, 0); check("rd_prdata_a1", prdata_b, 0);
        step();
        sample(); check("rd_pready_a2", pready_b, 0); check("rd_prdata_a2", prdata_b, 0);
        check("rd_stb_a2", gstb_b, 0);
        step(); drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        sample();
        check("rd_pready", pready_b, 1); check("rd_prdata", prdata_b, 32'h1234_5678);
        check("rd_pslverr", pslverr_b, 0);
        step();
        sample(); check("rd_pready_off", pready_b, 0); check("rd_prdata_off", prdata_b, 0);
        check("perr_overrun_a", perr_a, 1);
        step();

        // Decode errors on dut_a.
        drive(1, 0, 1, 32'h140, 32'hCAFE_F00D, 4'hF);
        step(); penable = 1'b1;
        step(); drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        sample();
        check("oor_pready", pready_a, 1); check("oor_pslverr", pslverr_a, 1);
        check("oor_stb", gstb_a, 0); check("oor_we", gwe_a, 0);
        step();
        drive(1, 0, 0, 32'h102, 32'h0, 4'h0);
        step(); penable = 1'b1;
        step(); drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        sample();
        check("mis_pready", pready_a, 1); check("mis_pslverr", pslverr_a, 1);
        check("mis_prdata", prdata_a, 0); check("mis_stb", gstb_a, 0);
        step();

        err_clr = 1'b1;
        step(); err_clr = 1'b0;
        sample(); check("clr1_a", perr_a, 0); check("clr1_b", perr_b, 0);
        step();

        // Back-to-back writes on dut_a: strobes two cycles apart, no violation.
        drive(1, 0, 1, 32'h100, 32'h1111_1111, 4'hF);
        step(); penable = 1'b1;
        step(); drive(1, 0, 1, 32'h104, 32'h2222_2222, 4'hF);
        sample(); check("b2b_stb1", gstb_a, 1); check("b2b_gaddr1", gaddr_a, 0);
        check("b2b_dat1", gdat_a, 32'h1111_1111); check("b2b_pready1", pready_a, 1);
        step(); penable = 1'b1;
        sample(); check("b2b_gap", gstb_a, 0); check("b2b_gaddr2_early", gaddr_a, 1);
        step(); drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        sample(); check("b2b_stb2", gstb_a, 1); check("b2b_dat2", gdat_a, 32'h2222_2222);
        check("b2b_pready2", pready_a, 1);
        step();
        sample(); check("b2b_stb_off", gstb_a, 0); check("b2b_perr_a", perr_a, 0);
        step();

        err_clr = 1'b1;
        step(); err_clr = 1'b0;
        sample(); check("clr2_b", perr_b, 0);
        step();

        // psel dropped while dut_b is waiting.
        drive(1, 0, 1, 32'h10C, 32'h3333_3333, 4'b0011);
        step(); penable = 1'b1;
        step(); drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        sample(); check("drop_pready_a1", pready_b, 0);
        step();
        sample(); check("drop_pready_c3", pready_b, 0); check("drop_perr_b", perr_b, 1);
        check("drop_perr_a", perr_a, 0);
        step();
        sample(); check("drop_pready_c4", pready_b, 0);
        step();

        // Set-dominant proto_err on dut_a.
        drive(1, 1, 0, 32'h100, 32'h0, 4'h0); err_clr = 1'b1;
        step(); drive(0, 0, 0, 32'h0, 32'h0, 4'h0); err_clr = 1'b0;
        sample(); check("perr_set_dominant", perr_a, 1);
        step(); err_clr = 1'b1;
        step(); err_clr = 1'b0;
        sample(); check("perr_clr_alone", perr_a, 0);
        step();

        // irq: registered on dut_a, pass-through on dut_b.
        gpio_inta_o = 1'b1;
        sample(); check("irq_b_rise", irq_b, 1); check("irq_a_rise_early", irq_a, 0);
        step();
        sample(); check("irq_a_rise", irq_a, 1);
        step(); gpio_inta_o = 1'b0;
        sample(); check("irq_b_fall", irq_b, 0); check("irq_a_fall_early", irq_a, 1);
        step();
        sample(); check("irq_a_fall", irq_a, 0);
        step();

        // Reset in the middle of dut_b's ACCESS wait.
        drive(1, 0, 1, 32'h108, 32'h4444_4444, 4'hF);
        step(); penable = 1'b1;
        step();
        sample(); check("rst_pre_stb", gstb_b, 1);
        step();
        #2 prst = 1'b0;
        #1;
        check_all_zero("b");
        check_all_zero("a");
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        step();
        step(); prst = 1'b1;
        sample(); check("rst_rel_pready", pready_b, 0); check("rst_rel_stb", gstb_b, 0);
        step();
        sample(); check("rst_idle_pready", pready_b, 0); check("rst_idle_stb", gstb_b, 0);
        check("rst_idle_sel", gsel_b, 0);
        step();

        // Fresh transfer after reset proves dut_b restarted from IDLE.
        drive(1, 0, 0, 32'h104, 32'h0, 4'h0);
        step(); penable = 1'b1;
        step();
        sample(); check("post_rst_stb", gstb_b, 1); check("post_rst_gaddr", gaddr_b, 1);
        step();
        step(); drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        sample(); check("post_rst_pready", pready_b, 1);
        check("post_rst_prdata", prdata_b, 32'h1234_5678);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
